uart_image_ram_top: RTL and testbench

//  Top level of the UART image loader: 8N1 UART receiver, frame decoder, 12-bit RGB444 pixel RAM, echo transmitter.
//  A frame is 0x5A, IMG_WIDTH*IMG_HEIGHT pixels of 2 bytes each, then 0x5A. Pixels are written to RAM at consecutive addresses.

---
 rtl/uart_image_ram_top.sv | 356 +++++++++++++++++++++++++++++++++++
 tb/tb_uart_image_ram_top.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_image_ram_top.sv
// uart_image_ram_top
//   UART image loader. An 8N1 receiver feeds a frame decoder that stores
//   RGB444 pixels in an inferred 32768 x 12 RAM. When a frame is complete the
//   image is streamed back out of the RAM. Every received byte is echoed on TX.
//   Frame format: MARKER, IMG_WIDTH*IMG_HEIGHT pixels as 2 bytes each
//   (hi byte = pix[11:4], upper nibble of lo byte = pix[3:0]), MARKER.
// Ports
//   i_clk_sys, i_rst_n (sync, active-low), i_test_rx  : clock, reset, UART RX
//   o_test_tx                                         : UART TX echo
//   o_test_rcv_data/done                              : received byte + 1-cycle strobe
//   o_test_scd_data/valid                             : decoder payload byte + strobe
//   o_test_state                                      : decoder state, one-hot
//   o_test_ram_din/rdsig/addr/wre/rdflag              : RAM port view
//   o_test_image_receiving/complete/reading           : frame status flags
//   o_test_xpos/ypos/pixcnt/pixelcount/buffercnt      : pixel position and counters
// Handshake: there is no back-pressure anywhere. Each *_done / *_valid / wre /
//   rdflag strobe is high for exactly one cycle and its data is stable in that
//   cycle; consumers must take it then or lose it.
module uart_image_ram_top #(
  parameter int       CLK_FREQ   = 50_000_000,
  parameter int       BAUD_RATE  = 9600,
  parameter int       IMG_WIDTH  = 5,
  parameter int       IMG_HEIGHT = 4,
  parameter logic [7:0] MARKER   = 8'h5A
) (
  input  logic        i_clk_sys,
  input  logic        i_rst_n,
  input  logic        i_test_rx,
  output logic        o_test_tx,
  output logic [7:0]  o_test_rcv_data,
  output logic        o_test_rcv_done,
  output logic [7:0]  o_test_scd_data,
  output logic        o_test_scd_valid,
  output logic [7:0]  o_test_state,
  output logic [11:0] o_test_ram_din,
  output logic        o_test_ram_rdsig,
  output logic [14:0] o_test_ram_addr,
  output logic        o_test_ram_wre,
  output logic        o_test_ram_rdflag,
  output logic        o_test_image_receiving,
  output logic        o_test_image_complete,
  output logic        o_test_image_reading,
  output logic [11:0] o_test_xpos,
  output logic [11:0] o_test_ypos,
  output logic [14:0] o_test_pixcnt,
  output logic [7:0]  o_test_pixelcount,
  output logic [7:0]  o_test_buffercnt
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int NPIX         = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [14:0] LAST_PIX = 15'(NPIX - 1);
  localparam logic [11:0] LAST_COL = 12'(IMG_WIDTH - 1);

  // ---------------------------------------------------------------- RX path
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  logic       rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e  rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rcv_data_q, rcv_data_d;
  logic       rcv_done_q, rcv_done_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rcv_data_d = rcv_data_q;
    rcv_done_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        // Glitch filter: a start bit must still be low at its centre.
        if (rx_cnt_q == HALF_M1) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == FULL_M1) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RX_STOP: begin
        // The stop bit level is not checked: framing errors are delivered as-is.
        if (rx_cnt_q == FULL_M1) begin
          rx_state_d = RX_IDLE;
          rcv_data_d = rx_shift_q;
          rcv_done_d = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rcv_data_q <= '0;
      rcv_done_q <= 1'b0;
    end else begin
      rx_meta_q  <= i_test_rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rcv_data_q <= rcv_data_d;
      rcv_done_q <= rcv_done_d;
    end
  end

  // ---------------------------------------------------------------- TX path
  // Frame is shifted out LSB first from {stop, data, start}; a byte that
  // arrives while a frame is still going out is dropped.
  logic        tx_q, tx_d;
  logic        tx_busy_q, tx_busy_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic [9:0]  tx_shift_q, tx_shift_d;

  always_comb begin
    tx_d       = tx_q;
    tx_busy_d  = tx_busy_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    if (!tx_busy_q) begin
      if (rcv_done_q) begin
        tx_busy_d  = 1'b1;
        tx_shift_d = {1'b1, rcv_data_q, 1'b0};
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_d       = 1'b0;
      end
    end else if (tx_cnt_q == FULL_M1) begin
      tx_cnt_d = '0;
      if (tx_bit_q == 4'd9) begin
        tx_busy_d = 1'b0;
        tx_d      = 1'b1;
      end else begin
        tx_bit_d   = tx_bit_q + 4'd1;
        tx_shift_d = {1'b1, tx_shift_q[9:1]};
        tx_d       = tx_shift_q[1];
      end
    end else begin
      tx_cnt_d = tx_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_n) begin
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '1;
    end else begin
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  // ---------------------------------------------------------------- decoder
  typedef enum logic [7:0] {
    S_IDLE = 8'h01,
    S_RECV = 8'h02,
    S_WAIT = 8'h04,
    S_READ = 8'h08
  } dec_state_e;

  dec_state_e  state_q, state_d;
  logic [14:0] pixcnt_q, pixcnt_d;
  logic        buffercnt_q, buffercnt_d;
  logic [11:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic [11:0] xpos_nx, ypos_nx;
  logic [11:0] pix_q, pix_d;
  logic        wre_q, wre_d;
  logic [14:0] rd_addr_q, rd_addr_d;
  logic        rdflag_q, rdflag_d;
  logic        complete_q, complete_d;
  logic [7:0]  scd_data_q, scd_data_d;
  logic        scd_valid_q, scd_valid_d;
  logic [11:0] rd_data_q;
  logic        rdsig;
  logic [11:0] mem [0:32767];

  // Raster step shared by the write and read sweeps.
  always_comb begin
    xpos_nx = xpos_q + 12'd1;
    ypos_nx = ypos_q;
    if (xpos_q == LAST_COL) begin
      xpos_nx = '0;
      ypos_nx = ypos_q + 12'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    pixcnt_d    = pixcnt_q;
    buffercnt_d = buffercnt_q;
    xpos_d      = xpos_q;
    ypos_d      = ypos_q;
    pix_d       = pix_q;
    wre_d       = 1'b0;
    rd_addr_d   = rd_addr_q;
    complete_d  = complete_q;
    scd_data_d  = scd_data_q;
    scd_valid_d = 1'b0;
    // Read data comes back one cycle after each READ-state address.
    rdflag_d    = (state_q == S_READ);
    case (state_q)
      S_IDLE: begin
        if (rcv_done_q && rcv_data_q == MARKER) begin
          state_d     = S_RECV;
          pixcnt_d    = '0;
          buffercnt_d = 1'b0;
          xpos_d      = '0;
          ypos_d      = '0;
          complete_d  = 1'b0;
        end
      end
      S_RECV: begin
        // Inside a frame the marker value is ordinary payload.
        if (rcv_done_q) begin
          scd_valid_d = 1'b1;
          scd_data_d  = rcv_data_q;
          if (!buffercnt_q) begin
            pix_d[11:4] = rcv_data_q;
            buffercnt_d = 1'b1;
          end else begin
            pix_d[3:0] = rcv_data_q[7:4];
            wre_d      = 1'b1;
          end
        end
        // Counters advance after the write cycle so x/y/pixcnt name the
        // pixel being written while wre is high.
        if (wre_q) begin
          pixcnt_d    = pixcnt_q + 15'd1;
          buffercnt_d = 1'b0;
          xpos_d      = xpos_nx;
          ypos_d      = ypos_nx;
          if (pixcnt_q == LAST_PIX) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rcv_done_q && rcv_data_q == MARKER) begin
          complete_d = 1'b1;
          state_d    = S_READ;
          rd_addr_d  = '0;
          xpos_d     = '0;
          ypos_d     = '0;
        end
      end
      S_READ: begin
        xpos_d = xpos_nx;
        ypos_d = ypos_nx;
        if (rd_addr_q == LAST_PIX) state_d   = S_IDLE;
        else                       rd_addr_d = rd_addr_q + 15'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      pixcnt_q    <= '0;
      buffercnt_q <= 1'b0;
      xpos_q      <= '0;
      ypos_q      <= '0;
      pix_q       <= '0;
      wre_q       <= 1'b0;
      rd_addr_q   <= '0;
      rdflag_q    <= 1'b0;
      complete_q  <= 1'b0;
      scd_data_q  <= '0;
      scd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pixcnt_q    <= pixcnt_d;
      buffercnt_q <= buffercnt_d;
      xpos_q      <= xpos_d;
      ypos_q      <= ypos_d;
      pix_q       <= pix_d;
      wre_q       <= wre_d;
      rd_addr_q   <= rd_addr_d;
      rdflag_q    <= rdflag_d;
      complete_q  <= complete_d;
      scd_data_q  <= scd_data_d;
      scd_valid_q <= scd_valid_d;
    end
  end

  // ---------------------------------------------------------------- RAM
  // Contents survive reset. Writes only happen in RECV and reads only in
  // READ, so the port is never asked to do both in one cycle.
  assign rdsig = (state_q == S_READ);

  always_ff @(posedge i_clk_sys) begin
    if (wre_q) mem[pixcnt_q] <= pix_q;
    if (rdsig) rd_data_q <= mem[rd_addr_q];
  end

  // ---------------------------------------------------------------- outputs
  assign o_test_tx              = tx_q;
  assign o_test_rcv_data        = rcv_data_q;
  assign o_test_rcv_done        = rcv_done_q;
  assign o_test_scd_data        = scd_data_q;
  assign o_test_scd_valid       = scd_valid_q;
  assign o_test_state           = state_q;
  assign o_test_ram_din         = rdflag_q ? rd_data_q : pix_q;
  assign o_test_ram_rdsig       = rdsig;
  assign o_test_ram_addr        = rdsig ? rd_addr_q : pixcnt_q;
  assign o_test_ram_wre         = wre_q;
  assign o_test_ram_rdflag      = rdflag_q;
  assign o_test_image_receiving = (state_q == S_RECV) || (state_q == S_WAIT);
  assign o_test_image_complete  = complete_q;
  assign o_test_image_reading   = (state_q == S_READ);
  assign o_test_xpos            = xpos_q;
  assign o_test_ypos            = ypos_q;
  assign o_test_pixcnt          = pixcnt_q;
  assign o_test_pixelcount      = pixcnt_q[7:0];
  assign o_test_buffercnt       = {7'd0, buffercnt_q};

endmodule

// File: tb/tb_uart_image_ram_top.sv
// Bench for uart_image_ram_top with a short bit time (8 clocks per bit).
// A frame-level reference model turns every sent byte into expected RX,
// echo, payload, RAM-write and RAM-read queues; monitors drain them.
module tb_uart_image_ram_top;
  localparam int CLK_FREQ  = 800_000;
  localparam int BAUD_RATE = 100_000;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;
  localparam int W         = 5;
  localparam int H         = 4;
  localparam int NPIX      = W * H;
  localparam logic [7:0] MARKER = 8'h5A;

  // ---------------------------------------------------------- clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  always #5 clk = ~clk;

  logic        o_tx, o_rcv_done, o_scd_valid, o_rdsig, o_wre, o_rdflag;
  logic        o_receiving, o_complete, o_reading;
  logic [7:0]  o_rcv_data, o_scd_data, o_state, o_pixelcount, o_buffercnt;
  logic [11:0] o_din, o_xpos, o_ypos;
  logic [14:0] o_addr, o_pixcnt;

  uart_image_ram_top #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE),
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .MARKER(MARKER)
  ) dut (
    .i_clk_sys(clk), .i_rst_n(rst_n), .i_test_rx(rx),
    .o_test_tx(o_tx),
    .o_test_rcv_data(o_rcv_data), .o_test_rcv_done(o_rcv_done),
    .o_test_scd_data(o_scd_data), .o_test_scd_valid(o_scd_valid),
    .o_test_state(o_state),
    .o_test_ram_din(o_din), .o_test_ram_rdsig(o_rdsig),
    .o_test_ram_addr(o_addr), .o_test_ram_wre(o_wre),
    .o_test_ram_rdflag(o_rdflag),
    .o_test_image_receiving(o_receiving),
    .o_test_image_complete(o_complete),
    .o_test_image_reading(o_reading),
    .o_test_xpos(o_xpos), .o_test_ypos(o_ypos),
    .o_test_pixcnt(o_pixcnt), .o_test_pixelcount(o_pixelcount),
    .o_test_buffercnt(o_buffercnt)
  );

  // ---------------------------------------------------------- checking
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------------------------------------------------- reference model
  int          m_mode;        // 0 idle, 1 collecting pixels, 2 awaiting closing marker
  int          m_cnt;
  bit          m_have_hi;
  bit          m_complete;
  logic [7:0]  m_hi;
  logic [11:0] m_img [NPIX];

  logic [7:0]  exp_rcv_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [7:0]  exp_scd_q[$];
  logic [26:0] exp_wr_q[$];   // {addr, pixel}
  logic [11:0] exp_rd_q[$];

  function automatic logic [7:0] m_state_code();
    case (m_mode)
      1:       return 8'h02;
      2:       return 8'h04;
      default: return 8'h01;
    endcase
  endfunction

  task automatic model_byte(input logic [7:0] b);
    logic [11:0] px;
    exp_rcv_q.push_back(b);
    exp_tx_q.push_back(b);
    case (m_mode)
      0: if (b == MARKER) begin
        m_mode = 1; m_cnt = 0; m_have_hi = 0; m_complete = 0;
      end
      1: begin
        exp_scd_q.push_back(b);
        if (!m_have_hi) begin
          m_hi = b; m_have_hi = 1;
        end else begin
          px = {m_hi, b[7:4]};
          exp_wr_q.push_back({15'(m_cnt), px});
          m_img[m_cnt] = px;
          m_cnt++;
          m_have_hi = 0;
          if (m_cnt == NPIX) m_mode = 2;
        end
      end
      default: if (b == MARKER) begin
        m_complete = 1;
        for (int i = 0; i < NPIX; i++) exp_rd_q.push_back(m_img[i]);
        m_mode = 0;
      end
    endcase
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_have_hi = 0; m_complete = 0;
  endtask

  // ---------------------------------------------------------- driver tasks
  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);  // stop bit plus two idle bits
  endtask

  task automatic send_pixel(input logic [11:0] px, input logic [3:0] lo_nib);
    send_byte(px[11:4]);
    send_byte({px[3:0], lo_nib});
  endtask

  task automatic idle_bits(input int n);
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic check_position(input string tag);
    check({tag, "_pixcnt"}, 32'(o_pixcnt), 32'(m_cnt));
    check({tag, "_xpos"},   32'(o_xpos),   32'(m_cnt % W));
    check({tag, "_ypos"},   32'(o_ypos),   32'(m_cnt / W));
  endtask

  // ---------------------------------------------------------- scoreboard monitors
  int   rd_idx = 0;
  int   rdsig_cnt = 0;
  int   read_state_cnt = 0;
  logic prev_rdsig = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_rcv_done) begin
        if (exp_rcv_q.size() == 0) check("rcv_unexpected", 1, 0);
        else check("rcv_data", 32'(o_rcv_data), 32'(exp_rcv_q.pop_front()));
      end
      if (o_scd_valid) begin
        if (exp_scd_q.size() == 0) check("scd_unexpected", 1, 0);
        else check("scd_data", 32'(o_scd_data), 32'(exp_scd_q.pop_front()));
      end
      if (o_wre) begin
        if (exp_wr_q.size() == 0) check("wre_unexpected", 1, 0);
        else begin
          logic [26:0] e;
          e = exp_wr_q.pop_front();
          check("wr_addr", 32'(o_addr), 32'(e[26:12]));
          check("wr_din",  32'(o_din),  32'(e[11:0]));
          check("wr_xpos", 32'(o_xpos), 32'(e[26:12]) % W);
          check("wr_ypos", 32'(o_ypos), 32'(e[26:12]) / W);
        end
      end
      if (o_rdsig) begin
        if (!prev_rdsig) rd_idx = 0;
        check("rd_addr", 32'(o_addr), 32'(rd_idx));
        check("rd_xpos", 32'(o_xpos), 32'(rd_idx % W));
        check("rd_ypos", 32'(o_ypos), 32'(rd_idx / W));
        rd_idx++;
        rdsig_cnt++;
      end
      if (o_state == 8'h08) read_state_cnt++;
      if (prev_rdsig || o_rdflag) check("rdflag_latency", 32'(o_rdflag), 32'(prev_rdsig));
      if (o_rdflag) begin
        if (exp_rd_q.size() == 0) check("rd_unexpected", 1, 0);
        else check("rd_din", 32'(o_din), 32'(exp_rd_q.pop_front()));
      end
      prev_rdsig = o_rdsig;
    end else begin
      prev_rdsig = 1'b0;
    end
  end

  // TX echo decoder: samples each bit near its centre.
  initial begin
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (rst_n && o_tx === 1'b0) begin
        repeat (CPB / 2 - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          d[i] = o_tx;
        end
        repeat (CPB) @(negedge clk);
        check("tx_stop", 32'(o_tx), 1);
        if (exp_tx_q.size() == 0) check("tx_unexpected", 1, 0);
        else check("tx_byte", 32'(d), 32'(exp_tx_q.pop_front()));
      end
    end
  end

  // Watchdog: the sequence is time-driven, this only guards against a stall.
  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected sequence end");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------------------------------------------------- main sequence
  initial begin
    int snap_sig, snap_state;
    model_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state",     32'(o_state), 32'h01);
    check("rst_tx",        32'(o_tx), 1);
    check("rst_pixcnt",    32'(o_pixcnt), 0);
    check("rst_rcv_done",  32'(o_rcv_done), 0);
    check("rst_rcv_data",  32'(o_rcv_data), 0);
    check("rst_wre",       32'(o_wre), 0);
    check("rst_complete",  32'(o_complete), 0);
    check("rst_addr",      32'(o_addr), 0);
    check("rst_din",       32'(o_din), 0);
    check("rst_buffercnt", 32'(o_buffercnt), 0);
    rst_n = 1'b1;
    idle_bits(2);

    // Opening marker and first pixel 12'hA3C.
    send_byte(MARKER);
    check("t1_state", 32'(o_state), 32'(m_state_code()));
    check("t1_receiving", 32'(o_receiving), 1);
    send_byte(8'hA3);
    check("t1_rcv_data", 32'(o_rcv_data), 32'h A3);
    check("t1_buffercnt", 32'(o_buffercnt), 1);
    send_byte(8'hC0);
    check_position("t2");
    check("t2_buffercnt", 32'(o_buffercnt), 0);

    // Rest of the frame, with marker-valued payload bytes in both halves.
    for (int i = 1; i < NPIX; i++) begin
      logic [11:0] px;
      logic [3:0]  nib;
      px  = 12'($urandom_range(0, 4095));
      nib = 4'($urandom_range(0, 15));
      if (i == 3) px[11:4] = MARKER;
      if (i == 8) begin px[3:0] = MARKER[7:4]; nib = MARKER[3:0]; end
      send_pixel(px, nib);
    end
    check("t3_state", 32'(o_state), 32'(m_state_code()));
    check_position("t3");
    check("t3_complete", 32'(o_complete), 0);

    // Stray byte while waiting for the closing marker.
    send_byte(8'h11);
    check("t5_state", 32'(o_state), 32'(m_state_code()));

    snap_sig   = rdsig_cnt;
    snap_state = read_state_cnt;
    send_byte(MARKER);
    idle_bits(4);
    check("t4_rdsig_cycles", 32'(rdsig_cnt - snap_sig), NPIX);
    check("t4_read_cycles",  32'(read_state_cnt - snap_state), NPIX);
    check("t4_state",        32'(o_state), 32'(m_state_code()));
    check("t4_complete",     32'(o_complete), 32'(m_complete));
    check("t4_rd_left",      32'(exp_rd_q.size()), 0);

    // Abort a frame with a one-cycle reset after 7 pixels.
    send_byte(MARKER);
    for (int i = 0; i < 7; i++) send_pixel(12'($urandom_range(0, 4095)), 4'($urandom_range(0, 15)));
    idle_bits(12);
    check_position("t6_pre");
    check("t6_queues_drained", 32'(exp_tx_q.size() + exp_wr_q.size() + exp_rcv_q.size()), 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check("t6_pixcnt",   32'(o_pixcnt), 0);
    check("t6_state",    32'(o_state), 32'h01);
    check("t6_tx",       32'(o_tx), 1);
    check("t6_complete", 32'(o_complete), 0);
    idle_bits(2);

    // Fresh frame after the reset, starting again at address 0.
    send_byte(MARKER);
    for (int i = 0; i < NPIX; i++) send_pixel(12'($urandom_range(0, 4095)), 4'($urandom_range(0, 15)));
    check_position("t6_frame");
    snap_sig = rdsig_cnt;
    send_byte(MARKER);
    idle_bits(12);
    check("t6_rdsig_cycles", 32'(rdsig_cnt - snap_sig), NPIX);
    check("t6_end_state",    32'(o_state), 32'(m_state_code()));
    check("t6_end_complete", 32'(o_complete), 32'(m_complete));

    check("end_rcv_left", 32'(exp_rcv_q.size()), 0);
    check("end_tx_left",  32'(exp_tx_q.size()), 0);
    check("end_scd_left", 32'(exp_scd_q.size()), 0);
    check("end_wr_left",  32'(exp_wr_q.size()), 0);
    check("end_rd_left",  32'(exp_rd_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
